// File: rtl/sram_bus_master_if.sv
// Request/response and SRAM control signals shared between the bus master and its client.
// The bidirectional data bus stays a plain inout on the master so tristate resolution is simple.
interface sram_bus_master_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic          req;
    logic          wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          busy;
    logic          ack;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    logic          ncs;
    logic          nwe;
    logic          noe;

    modport master (
        input  req, wr, req_addr, req_wdata,
        output busy, ack, rdata, addr, ncs, nwe, noe
    );

    modport slave (
        output req, wr, req_addr, req_wdata,
        input  busy, ack, rdata, addr, ncs, nwe, noe
    );
endinterface

// File: rtl/sram_bus_master.sv
// Asynchronous SRAM bus master: one read or write per request with programmable
// setup/strobe/hold timing; every bus output comes straight from a register.
module sram_bus_master #(
    parameter int AW   = 10,
    parameter int DW   = 16,
    parameter int T_SU = 1,
    parameter int T_ST = 2,
    parameter int T_HD = 1
) (
    input  logic              clk,
    input  logic              reset,
    sram_bus_master_if.master bus,
    inout  wire  [DW-1:0]     sram_data
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] CNT_SU = 4'(T_SU);
    localparam logic [3:0] CNT_ST = 4'(T_ST);
    localparam logic [3:0] CNT_HD = 4'(T_HD);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          ncs_q, ncs_d;
    logic          nwe_q, nwe_d;
    logic          noe_q, noe_d;
    logic          drv_q, drv_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic          last_cyc;

    // The shared counter holds the cycles remaining in the current phase.
    assign last_cyc = (cnt_q == 4'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ncs_d   = ncs_q;
        nwe_d   = nwe_q;
        noe_d   = noe_q;
        drv_d   = drv_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    state_d = SETUP;
                    cnt_d   = CNT_SU;
                    wr_d    = bus.wr;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    drv_d   = bus.wr;
                end
            end
            SETUP: begin
                if (last_cyc) begin
                    state_d = STROBE;
                    cnt_d   = CNT_ST;
                    nwe_d   = ~wr_q;
                    noe_d   = wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (last_cyc) begin
                    state_d = HOLD;
                    cnt_d   = CNT_HD;
                    nwe_d   = 1'b1;
                    if (!wr_q) rdata_d = sram_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (last_cyc) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    ncs_d   = 1'b1;
                    noe_d   = 1'b1;
                    drv_d   = 1'b0;
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ncs_q   <= 1'b1;
            nwe_q   <= 1'b1;
            noe_q   <= 1'b1;
            drv_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ncs_q   <= ncs_d;
            nwe_q   <= nwe_d;
            noe_q   <= noe_d;
            drv_q   <= drv_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    // Latched request payload is only consumed while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        wdata_q <= wdata_d;
    end

    assign bus.busy  = busy_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.addr  = addr_q;
    assign bus.ncs   = ncs_q;
    assign bus.nwe   = nwe_q;
    assign bus.noe   = noe_q;
    assign sram_data = drv_q ? wdata_q : {DW{1'bz}};
endmodule

// File: tb/tb_sram_bus_master.sv
// Bench for sram_bus_master: table of transactions checked through a scoreboard,
// plus hand sequences for back-to-back, busy, reset-abort and non-default timing.
module tb_sram_bus_master;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int SU = 1;
    localparam int ST = 2;
    localparam int HD = 1;
    localparam int TOT = SU + ST + HD;
    localparam logic [31:0] NWE_PAT = ((32'd1 << ST) - 32'd1) << SU;
    localparam logic [31:0] NOE_PAT = ((32'd1 << (ST + HD)) - 32'd1) << SU;

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
    } txn_t;

    logic clk;
    logic reset;
    logic mem_clr;
    int   checks = 0;
    int   failures = 0;
    int   ack_cnt = 0;
    int   exp_acks = 0;

    sram_bus_master_if #(.AW(AW), .DW(DW)) bif();
    sram_bus_master_if #(.AW(AW), .DW(DW)) bif2();
    wire [DW-1:0] sram_data;
    wire [DW-1:0] sram_data2;

    sram_bus_master #(.AW(AW), .DW(DW), .T_SU(SU), .T_ST(ST), .T_HD(HD)) dut1 (
        .clk(clk), .reset(reset), .bus(bif), .sram_data(sram_data));
    sram_bus_master #(.AW(AW), .DW(DW), .T_SU(2), .T_ST(5), .T_HD(3)) dut2 (
        .clk(clk), .reset(reset), .bus(bif2), .sram_data(sram_data2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        return (a == 10'h010) ? 16'h1234 : ({6'd0, a} ^ 16'h5A00);
    endfunction

    // SRAM model: writes on the clock while ncs and nwe are low, reads drive while noe is low.
    logic [DW-1:0] mem [0:1023];
    logic [1023:0] wrt;
    logic [DW-1:0] sram_rd;
    always @(posedge clk) begin
        if (mem_clr) wrt <= '0;
        else if (!bif.ncs && !bif.nwe) begin
            mem[bif.addr] <= sram_data;
            wrt[bif.addr] <= 1'b1;
        end
    end
    assign sram_rd    = wrt[bif.addr] ? mem[bif.addr] : init_pat(bif.addr);
    assign sram_data  = !bif.noe ? sram_rd : {DW{1'bz}};
    assign sram_data2 = !bif2.noe ? 16'hC0DE : {DW{1'bz}};

    txn_t          sb[$];
    logic [DW-1:0] shadow [int];
    logic [DW-1:0] last_rd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push_txn(input txn_t t);
        sb.push_back(t);
        exp_acks++;
        if (t.wr) shadow[int'(t.a)] = t.wd;
        else last_rd = t.rd;
    endtask

    task automatic push_exp(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.wr = w; t.a = a; t.wd = d;
        if (w) t.rd = last_rd;
        else t.rd = shadow.exists(int'(a)) ? shadow[int'(a)] : init_pat(a);
        push_txn(t);
    endtask

    // Called at a negedge with the DUT idle; returns one cycle later, inside SETUP.
    task automatic drive_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bif.req = 1'b1; bif.wr = w; bif.req_addr = a; bif.req_wdata = d;
        @(negedge clk);
        check("accept", 32'(bif.busy), 32'd1);
        bif.req = 1'b0; bif.wr = ~w; bif.req_addr = ~a; bif.req_wdata = ~d;
    endtask

    task automatic wait_ack(input string nm);
        int n = 0;
        while (!bif.ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(bif.ack), 32'd1);
    endtask

    task automatic run_dut2(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int lat, output int nwe_n, output int noe_n,
                            output int first_nwe, output int derr);
        bif2.req = 1'b1; bif2.wr = w; bif2.req_addr = a; bif2.req_wdata = d;
        @(negedge clk);
        bif2.req = 1'b0;
        lat = 0; nwe_n = 0; noe_n = 0; first_nwe = 0; derr = 0;
        while (!bif2.ack && lat < 40) begin
            if (!bif2.nwe) begin
                if (nwe_n == 0) first_nwe = lat;
                nwe_n++;
            end
            if (!bif2.noe) noe_n++;
            if (w && sram_data2 !== d) derr++;
            @(negedge clk);
            lat++;
        end
    endtask

    // Monitor: gathers per-transaction bus behaviour and scores it when ack appears.
    initial begin
        int ncs_cnt, busy_cnt, addr_err, data_err, ovl_err, idle_err;
        logic [31:0] nwe_pat, noe_pat;
        logic prev_ncs_low, prev_ack;
        txn_t e;
        ncs_cnt = 0; busy_cnt = 0; addr_err = 0; data_err = 0; ovl_err = 0; idle_err = 0;
        nwe_pat = '0; noe_pat = '0; prev_ncs_low = 1'b0; prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ncs_cnt = 0; busy_cnt = 0; addr_err = 0; data_err = 0; ovl_err = 0; idle_err = 0;
                nwe_pat = '0; noe_pat = '0; prev_ncs_low = 1'b0; prev_ack = 1'b0;
            end else begin
                if (!bif.nwe && !bif.noe) ovl_err++;
                if (!bif.ncs) begin
                    if (sb.size() == 0) idle_err++;
                    else begin
                        if (bif.addr !== sb[0].a) addr_err++;
                        if (sb[0].wr && (sram_data !== sb[0].wd || !dut1.drv_q)) data_err++;
                        if (!sb[0].wr && dut1.drv_q) data_err++;
                    end
                    if (!bif.nwe) nwe_pat[ncs_cnt[4:0]] = 1'b1;
                    if (!bif.noe) noe_pat[ncs_cnt[4:0]] = 1'b1;
                    if (bif.busy) busy_cnt++;
                    ncs_cnt++;
                end else if (dut1.drv_q || !bif.nwe || !bif.noe || bif.busy) begin
                    idle_err++;
                end
                if (bif.ack) begin
                    ack_cnt++;
                    if (prev_ack) check("ack_pulse_width", 32'd2, 32'd1);
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("txn_ncs_cycles", 32'(ncs_cnt), 32'(TOT));
                        check("txn_busy_cycles", 32'(busy_cnt), 32'(TOT));
                        check("txn_nwe_pattern", nwe_pat, e.wr ? NWE_PAT : 32'd0);
                        check("txn_noe_pattern", noe_pat, e.wr ? 32'd0 : NOE_PAT);
                        check("txn_addr_errors", 32'(addr_err), 32'd0);
                        check("txn_addr_in_idle", 32'(bif.addr), 32'(e.a));
                        check("txn_data_errors", 32'(data_err), 32'd0);
                        check("txn_rdata", 32'(bif.rdata), 32'(e.rd));
                        check("txn_ack_after_hold", 32'(prev_ncs_low), 32'd1);
                        check("txn_nwe_noe_overlap", 32'(ovl_err), 32'd0);
                        check("txn_idle_errors", 32'(idle_err), 32'd0);
                    end
                    ncs_cnt = 0; busy_cnt = 0; addr_err = 0; data_err = 0; ovl_err = 0; idle_err = 0;
                    nwe_pat = '0; noe_pat = '0;
                end
                prev_ack = bif.ack;
                prev_ncs_low = !bif.ncs;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    txn_t tbl [8];
    initial begin
        int acks_before, lat, nwe_n, noe_n, first_nwe, derr;
        tbl[0] = '{wr: 1'b1, a: 10'h3A5, wd: 16'hBEEF, rd: 16'h0000};
        tbl[1] = '{wr: 1'b0, a: 10'h010, wd: 16'h0000, rd: 16'h1234};
        tbl[2] = '{wr: 1'b1, a: 10'h3FF, wd: 16'hFFFF, rd: 16'h1234};
        tbl[3] = '{wr: 1'b0, a: 10'h3FF, wd: 16'h0000, rd: 16'hFFFF};
        tbl[4] = '{wr: 1'b1, a: 10'h000, wd: 16'h0000, rd: 16'hFFFF};
        tbl[5] = '{wr: 1'b0, a: 10'h000, wd: 16'hFFFF, rd: 16'h0000};
        tbl[6] = '{wr: 1'b0, a: 10'h155, wd: 16'h0000, rd: 16'h5B55};
        tbl[7] = '{wr: 1'b0, a: 10'h3A5, wd: 16'h0000, rd: 16'hBEEF};

        reset = 1'b1; mem_clr = 1'b1; last_rd = '0;
        bif.req = 1'b0; bif.wr = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;
        bif2.req = 1'b0; bif2.wr = 1'b0; bif2.req_addr = '0; bif2.req_wdata = '0;
        #1 reset = 1'b0;
        #1;
        check("rst_ncs", 32'(bif.ncs), 32'd1);
        check("rst_nwe", 32'(bif.nwe), 32'd1);
        check("rst_noe", 32'(bif.noe), 32'd1);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_ack", 32'(bif.ack), 32'd0);
        check("rst_addr", 32'(bif.addr), 32'd0);
        check("rst_rdata", 32'(bif.rdata), 32'd0);
        check("rst_data_released", 32'(dut1.drv_q), 32'd0);
        check("rst_dut2_ncs", 32'(bif2.ncs), 32'd1);
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        reset = 1'b1;

        // First request right at the release edge, then the rest of the table.
        for (int i = 0; i < 8; i++) begin
            push_txn(tbl[i]);
            drive_req(tbl[i].wr, tbl[i].a, tbl[i].wd);
            wait_ack($sformatf("tbl%0d_ack", i));
            @(negedge clk);
        end

        // Back-to-back write then read with req held high throughout.
        push_exp(1'b1, 10'h001, 16'h5A5A);
        bif.req = 1'b1; bif.wr = 1'b1; bif.req_addr = 10'h001; bif.req_wdata = 16'h5A5A;
        @(negedge clk);
        check("b2b_first_accept", 32'(bif.busy), 32'd1);
        bif.wr = 1'b0; bif.req_wdata = 16'h0F0F;
        wait_ack("b2b_first_ack");
        check("b2b_gap_ncs_high", 32'(bif.ncs), 32'd1);
        push_exp(1'b0, 10'h001, 16'h0000);
        @(negedge clk);
        check("b2b_second_ncs_low", 32'(bif.ncs), 32'd0);
        bif.req = 1'b0;
        wait_ack("b2b_second_ack");
        @(negedge clk);

        // Request pulsed during STROBE must be ignored.
        push_exp(1'b1, 10'h2AA, 16'h1111);
        drive_req(1'b1, 10'h2AA, 16'h1111);
        @(negedge clk);
        check("busy_in_strobe", 32'(bif.nwe), 32'd0);
        bif.req = 1'b1; bif.wr = 1'b0; bif.req_addr = 10'h155;
        @(negedge clk);
        bif.req = 1'b0;
        wait_ack("busy_ack");
        acks_before = ack_cnt;
        repeat (6) @(negedge clk);
        check("busy_no_extra_ack", 32'(ack_cnt), 32'(acks_before));
        check("busy_addr_kept", 32'(bif.addr), 32'h2AA);
        check("busy_stays_idle", 32'(bif.ncs), 32'd1);

        // Reset during STROBE of a write aborts it immediately.
        push_exp(1'b1, 10'h0F0, 16'h7777);
        drive_req(1'b1, 10'h0F0, 16'h7777);
        @(negedge clk);
        check("abort_in_strobe", 32'(bif.nwe), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("abort_ncs", 32'(bif.ncs), 32'd1);
        check("abort_nwe", 32'(bif.nwe), 32'd1);
        check("abort_noe", 32'(bif.noe), 32'd1);
        check("abort_data_released", 32'(dut1.drv_q), 32'd0);
        check("abort_busy", 32'(bif.busy), 32'd0);
        check("abort_addr", 32'(bif.addr), 32'd0);
        sb.delete();
        exp_acks--;
        shadow.delete(int'(10'h0F0));
        last_rd = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        acks_before = ack_cnt;
        repeat (5) @(negedge clk);
        check("abort_no_ack", 32'(ack_cnt), 32'(acks_before));
        check("abort_rdata_cleared", 32'(bif.rdata), 32'd0);
        push_exp(1'b0, 10'h010, 16'h0000);
        drive_req(1'b0, 10'h010, 16'h0000);
        wait_ack("post_reset_read_ack");
        @(negedge clk);

        // Non-default timing: T_SU=2, T_ST=5, T_HD=3.
        run_dut2(1'b1, 10'h123, 16'hA5A5, lat, nwe_n, noe_n, first_nwe, derr);
        check("slow_wr_latency", 32'(lat), 32'd10);
        check("slow_wr_nwe_cycles", 32'(nwe_n), 32'd5);
        check("slow_wr_nwe_start", 32'(first_nwe), 32'd2);
        check("slow_wr_noe_cycles", 32'(noe_n), 32'd0);
        check("slow_wr_data", 32'(derr), 32'd0);
        @(negedge clk);
        run_dut2(1'b0, 10'h123, 16'h0000, lat, nwe_n, noe_n, first_nwe, derr);
        check("slow_rd_latency", 32'(lat), 32'd10);
        check("slow_rd_noe_cycles", 32'(noe_n), 32'd8);
        check("slow_rd_nwe_cycles", 32'(nwe_n), 32'd0);
        check("slow_rd_rdata", 32'(bif2.rdata), 32'hC0DE);
        @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("ack_total", 32'(ack_cnt), 32'(exp_acks));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_bus_master.md
SRAM_BUS_MASTER -- requirements
Module: sram_bus_master

Interface
REQ-001 Parameter AW, default 10: width of the address bus.
REQ-002 Parameter DW, default 16: width of the data bus.
REQ-003 Parameter T_SU, default 1: setup cycles, legal range 1..15.
REQ-004 Parameter T_ST, default 2: strobe cycles, legal range 1..15.
REQ-005 Parameter T_HD, default 1: hold cycles, legal range 1..15.
REQ-006 Port clk, input, 1: single clock; all state SHALL update on posedge clk.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port req, input, 1: transaction request, sampled only in IDLE.
REQ-009 Port wr, input, 1: transaction type; 1 = write, 0 = read; sampled with req.
REQ-010 Port req_addr, input, AW: transaction address.
REQ-011 Port req_wdata, input, DW: write data.
REQ-012 Port busy, output, 1: high in every state other than IDLE.
REQ-013 Port ack, output, 1: one-cycle pulse marking transaction completion.
REQ-014 Port rdata, output, DW: read data; valid while ack=1 for a read, held until the next read completes.
REQ-015 Port addr, output, AW: bus address.
REQ-016 Port ncs, output, 1: active-low chip select.
REQ-017 Port nwe, output, 1: active-low write enable.
REQ-018 Port noe, output, 1: active-low output enable.
REQ-019 Port sram_data, inout, DW: bidirectional bus data.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, STROBE and HOLD, with one shared down-counter of at least 4 bits.
REQ-021 IDLE with req=1 at a clock edge: latch wr, req_addr and req_wdata, load the counter with T_SU, and go to SETUP.
REQ-022 SETUP lasts T_SU cycles, then goes to STROBE with the counter loaded to T_ST.
REQ-023 STROBE lasts T_ST cycles, then goes to HOLD with the counter loaded to T_HD.
REQ-024 HOLD lasts T_HD cycles, then goes to IDLE.
REQ-025 All bus outputs, ack and busy SHALL be driven from registers (no combinational paths from req).
REQ-026 ncs SHALL be low in SETUP, STROBE and HOLD, and high in IDLE.
REQ-027 IDLE SHALL last at least one cycle, so ncs is high for at least one cycle between transactions.
REQ-028 addr SHALL hold the latched address from SETUP through HOLD and keep that value in IDLE.
REQ-029 Write: nwe SHALL be low only in STROBE, for exactly T_ST cycles.
REQ-030 Write: sram_data SHALL be driven with the latched data from SETUP through HOLD, and be Z otherwise.
REQ-031 Read: noe SHALL be low in STROBE and HOLD; sram_data SHALL never be driven by this block.
REQ-032 Read: rdata SHALL capture sram_data at the edge ending the last STROBE cycle.
REQ-033 ack SHALL be 1 exactly during the first IDLE cycle after HOLD.
REQ-034 Latency: with acceptance at edge E0, ack rises at edge E0+T_SU+T_ST+T_HD; 4 cycles at defaults.
REQ-035 Back-to-back: req=1 during the ack cycle SHALL be accepted at the edge ending that cycle.
REQ-036 req, wr, req_addr and req_wdata SHALL be ignored while busy=1; requests are not queued.
REQ-037 nwe and noe SHALL never be low in the same cycle.
REQ-038 sram_data SHALL never be driven while noe=0.

Reset
REQ-039 While reset=0, asynchronously: state=IDLE, ncs=nwe=noe=1, sram_data=Z, addr=0, rdata=0, ack=0, busy=0, counter=0.
REQ-040 Reset asserted mid-transaction SHALL abort it immediately, with no ack for the aborted transaction.
REQ-041 After reset release, the first request SHALL be accepted at the first edge at which req=1.

Verification
REQ-042 Write at defaults: wr=1, req_addr=0x3A5, req_wdata=0xBEEF -> ncs low for 4 cycles; nwe low for exactly 2 cycles, in cycles 2-3; sram_data=0xBEEF for all 4 cycles; ack at E0+4; busy high for 4 cycles.
REQ-043 Read at defaults: the bus model drives 0x1234 while noe=0 and address=0x010 -> noe low for 3 cycles; rdata=0x1234 at ack; sram_data never driven by the DUT.
REQ-044 Back-to-back: req held high for a write to 0x001 then a read of 0x001 -> 2 acks; ncs high for exactly 1 cycle between them; the read returns the written value from the SRAM model.
REQ-045 Request while busy: req pulses during STROBE -> ignored; exactly 1 ack; addr unchanged.
REQ-046 Reset during STROBE of a write -> ncs, nwe and noe go to 1 and sram_data goes to Z before the next edge; no ack; a subsequent read completes normally.
REQ-047 Parameters T_SU=2, T_ST=5, T_HD=3 -> nwe low for exactly 5 cycles; ack at E0+10.
